// File: rtl/cs_pkg.sv
// Shared constants and state type for the CS sliding-window sequencer.
package cs_pkg;

  localparam int CS_XW  = 8;
  localparam int CS_YW  = 10;
  localparam int CS_WIN = 9;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } cs_state_e;

endpackage

// File: rtl/cs_res_fifo.sv
// Synchronous result FIFO between the CS datapath and the result consumer.
module cs_res_fifo
  import cs_pkg::*;
#(
  parameter int YW    = CS_YW,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [YW-1:0]              push_data,
  input  logic                       pop,
  output logic [YW-1:0]              head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [YW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop & ~empty;

  // NOTE: the storage array has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/cs_stream_ctrl.sv
// Stream sequencer for the CS window: accepts samples, drives shift/clear,
// tags results past warm-up and buffers them with credit-based back-pressure.
module cs_stream_ctrl
  import cs_pkg::*;
#(
  parameter int WIN        = CS_WIN,
  parameter int XW         = CS_XW,
  parameter int YW         = CS_YW,
  parameter int DP_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_data,
  output logic          win_shift,
  output logic [XW-1:0] win_data,
  output logic          win_clear,
  input  logic [YW-1:0] dp_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [YW-1:0] out_y,
  output logic          busy
);

  localparam int             FW        = $clog2(WIN);
  localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0]  FILL_LAST = FW'(WIN - 1);

  cs_state_e         state, state_nx;
  logic [FW-1:0]     fill_cnt, fill_nx;
  logic              shift_tag;
  logic [DP_LAT-1:0] tag_pipe;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     credit_used;
  logic              fifo_full, fifo_empty;
  logic              accept, yields, drained;

  // Every sample that may still land in the FIFO holds a credit, so a push never finds it full.
  assign credit_used = fifo_cnt + CW'($countones(tag_pipe)) + CW'(win_shift);
  // Gated by reset so the handshake is dead while the flops are held clear.
  assign in_ready = reset & (state != FLUSH) & ~frame_start & ~fifo_full &
                    (credit_used < CW'(FIFO_DEPTH));
  assign accept   = in_valid & in_ready;
  assign yields   = (state == RUN) | (fill_cnt == FILL_LAST);
  assign drained  = ~(|tag_pipe) & ~win_shift;

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_nx  = state;
    fill_nx   = fill_cnt;
    win_clear = 1'b0;
    unique case (state)
      FILL: begin
        if (frame_start) begin
          state_nx = FLUSH;
        end else if (accept) begin
          if (fill_cnt == FILL_LAST) state_nx = RUN;
          else                       fill_nx  = fill_cnt + 1'b1;
        end
      end
      RUN: begin
        if (frame_start) state_nx = FLUSH;
      end
      FLUSH: begin
        if (drained) begin
          win_clear = 1'b1;
          fill_nx   = '0;
          state_nx  = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FILL;
      fill_cnt  <= '0;
      win_shift <= 1'b0;
      shift_tag <= 1'b0;
      win_data  <= '0;
      tag_pipe  <= '0;
    end else begin
      state     <= state_nx;
      fill_cnt  <= fill_nx;
      win_shift <= accept;
      shift_tag <= accept & yields;
      if (accept) win_data <= in_data;
      tag_pipe[0] <= shift_tag;
      for (int i = 1; i < DP_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  cs_res_fifo #(
    .YW    (YW),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_pipe[DP_LAT-1]),
    .push_data (dp_y),
    .pop       (out_valid & out_ready),
    .head      (out_y),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign out_valid = ~fifo_empty;
  assign busy      = (state != FILL) | (fill_cnt != '0) | ~fifo_empty | (|tag_pipe) | win_shift;

endmodule

// File: tb/tb_cs_stream_ctrl.sv
// Self-checking bench for cs_stream_ctrl: warm-up table, back-pressure, frame restart,
// reset, steady streaming and randomized traffic against a sliding-window sum model.
module tb_cs_stream_ctrl;
  import cs_pkg::*;

  localparam int WIN    = CS_WIN;
  localparam int XW     = CS_XW;
  localparam int YW     = CS_YW;
  localparam int DP_LAT = 1;
  localparam int DEPTH  = 4;
  localparam int NROWS  = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_data = '0;
  logic          win_shift;
  logic [XW-1:0] win_data;
  logic          win_clear;
  logic [YW-1:0] dp_y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [YW-1:0] out_y;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cs_stream_ctrl #(
    .WIN(WIN), .XW(XW), .YW(YW), .DP_LAT(DP_LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .win_shift   (win_shift),
    .win_data    (win_data),
    .win_clear   (win_clear),
    .dp_y        (dp_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .busy        (busy)
  );

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Stand-in CS datapath: window sum one cycle after each shift, noise otherwise.
  logic [XW-1:0] cs_win [WIN] = '{default: '0};
  int            stub_next;
  always_comb begin
    stub_next = int'(win_data);
    for (int i = 0; i < WIN - 1; i++) stub_next += int'(cs_win[i]);
  end
  always @(posedge clk) begin
    if (win_shift) begin
      cs_win[0] <= win_data;
      for (int i = 1; i < WIN; i++) cs_win[i] <= cs_win[i-1];
      dp_y <= YW'(stub_next);
    end else begin
      dp_y <= YW'($urandom);
      if (win_clear) for (int i = 0; i < WIN; i++) cs_win[i] <= '0;
    end
  end

  // Reference: every accepted sample that completes a WIN-long run inside the current
  // frame yields the sum of those WIN samples; results leave in acceptance order.
  int frame_q[$];
  int exp_q[$];
  int shift_cnt = 0;
  int clear_cnt = 0;
  int pop_cnt   = 0;

  function automatic int window_sum(input int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s % (1 << YW);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      frame_q.delete();
      exp_q.delete();
    end else begin
      if (win_shift) shift_cnt++;
      if (win_clear) clear_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else                   check("result_value", int'(out_y), exp_q.pop_front());
      end
      if (frame_start) begin
        check("ready_low_on_frame_start", int'(in_ready), 0);
        frame_q.delete();
      end
      if (in_valid && in_ready) begin
        frame_q.push_back(int'(in_data));
        if (frame_q.size() > WIN) void'(frame_q.pop_front());
        if (frame_q.size() == WIN) begin
          exp_q.push_back(window_sum(frame_q));
          check("outstanding_within_depth", int'(exp_q.size() <= DEPTH), 1);
        end
      end
    end
  end

  typedef struct {
    logic          v;
    logic [XW-1:0] d;
    logic          ordy;
    logic          e_ready;
    logic          e_shift;
    logic [XW-1:0] e_wdata;
    logic          e_ov;
    logic [YW-1:0] e_y;
    logic          e_busy;
  } vec_t;

  vec_t tbl [NROWS];

  task automatic drive(input logic v, input logic [XW-1:0] d, input logic fs, input logic ordy);
    @(posedge clk);
    #1;
    in_valid    = v;
    in_data     = d;
    frame_start = fs;
    out_ready   = ordy;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"},  int'(in_ready),  0);
    check({tag, "_win_shift"}, int'(win_shift), 0);
    check({tag, "_win_clear"}, int'(win_clear), 0);
    check({tag, "_win_data"},  int'(win_data),  0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_y"},     int'(out_y),     0);
    check({tag, "_busy"},      int'(busy),      0);
  endtask

  // Warm-up from a fresh FILL: samples 1..9 accepted in cycles 0..8, the single Y (=45)
  // appears at cycle 8+DP_LAT+2 and is taken immediately.
  task automatic run_table(input string tag);
    int s0;
    s0 = 0;
    for (int c = 0; c < NROWS; c++) begin
      drive(tbl[c].v, tbl[c].d, 1'b0, tbl[c].ordy);
      if (c == 0) s0 = shift_cnt;
      @(negedge clk);
      check($sformatf("%s_in_ready[%0d]", tag, c),  int'(in_ready),  int'(tbl[c].e_ready));
      check($sformatf("%s_win_shift[%0d]", tag, c), int'(win_shift), int'(tbl[c].e_shift));
      if (tbl[c].e_shift)
        check($sformatf("%s_win_data[%0d]", tag, c), int'(win_data), int'(tbl[c].e_wdata));
      check($sformatf("%s_out_valid[%0d]", tag, c), int'(out_valid), int'(tbl[c].e_ov));
      check($sformatf("%s_out_y[%0d]", tag, c),     int'(out_y),     int'(tbl[c].e_y));
      check($sformatf("%s_busy[%0d]", tag, c),      int'(busy),      int'(tbl[c].e_busy));
      check($sformatf("%s_win_clear[%0d]", tag, c), int'(win_clear), 0);
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    check({tag, "_shift_count"}, shift_cnt - s0, WIN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int   acc, p0, c0, s0, clear_at, accept_at, n, last_fs;
    logic fs;

    for (int c = 0; c < NROWS; c++) begin
      tbl[c].v       = (c < WIN);
      tbl[c].d       = XW'(c + 1);
      tbl[c].ordy    = 1'b1;
      tbl[c].e_ready = 1'b1;
      tbl[c].e_shift = (c >= 1 && c <= WIN);
      tbl[c].e_wdata = XW'(c);
      tbl[c].e_ov    = (c == WIN - 1 + DP_LAT + 2);
      tbl[c].e_y     = (c == WIN - 1 + DP_LAT + 2) ? YW'(45) : '0;
      tbl[c].e_busy  = (c != 0);
    end

    // Reset state
    @(posedge clk);
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // T1 warm-up
    run_table("t1");

    // T3 back-pressure: consumer stalled, source keeps offering
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, XW'(8'hA0 + acc), 1'b0, 1'b0);
      @(negedge clk);
      if (in_ready) acc++;
    end
    check("t3_accepts", acc, DEPTH);
    check("t3_out_valid", int'(out_valid), 1);
    check("t3_in_ready", int'(in_ready), 0);
    drive(1'b0, '0, 1'b0, 1'b1);
    p0 = pop_cnt;
    repeat (8) drive(1'b0, '0, 1'b0, 1'b1);
    check("t3_delivered", pop_cnt - p0, DEPTH);
    check("t3_model_empty", exp_q.size(), 0);

    // T4/T5 frame restart with two results in flight, sample offered on the same cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, XW'(i * 7 + 3), 1'b0, 1'b1);
      @(negedge clk);
    end
    drive(1'b1, 8'h55, 1'b1, 1'b1);
    c0 = clear_cnt;
    s0 = shift_cnt;
    @(negedge clk);
    check("t5_ready_low", int'(in_ready), 0);
    clear_at  = -1;
    accept_at = -1;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 8'h55, 1'b0, 1'b1);
      @(negedge clk);
      if (win_clear && clear_at < 0) clear_at = k;
      if (in_ready) begin
        accept_at = k;
        break;
      end
    end
    check("t4_clear_cycle", clear_at, DP_LAT + 1);
    check("t5_retry_accept_cycle", accept_at, DP_LAT + 2);
    drive(1'b1, 8'h01, 1'b0, 1'b1);
    check("t5_no_shift_in_flush", shift_cnt - s0, 1);
    check("t4_old_results_delivered", exp_q.size(), 0);
    @(negedge clk);
    check("t5_retry_shifted", int'(win_data), 8'h55);
    check("t4_warmup_no_y[1]", int'(out_valid), 0);
    for (int j = 2; j < WIN; j++) begin
      drive(1'b1, XW'(j), 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("t4_warmup_no_y[%0d]", j), int'(out_valid), 0);
      check($sformatf("t4_warmup_ready[%0d]", j), int'(in_ready), 1);
    end
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      if (out_valid) begin
        n = k;
        break;
      end
    end
    check("t4_first_y_latency", n, DP_LAT + 2);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t4_single_clear", clear_cnt - c0, 1);

    // T6 reset mid-RUN with FIFO occupied
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, XW'($urandom), 1'b0, 1'b0);
      @(negedge clk);
    end
    check("t6_fifo_occupied", int'(out_valid), 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_outputs_zero("t6_async");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_table("t6");

    // T2 steady streaming: one sample per cycle, ready never drops
    drive(1'b1, XW'($urandom), 1'b0, 1'b1);
    p0 = pop_cnt;
    @(negedge clk);
    check("t2_in_ready", int'(in_ready), 1);
    for (int i = 1; i < 300; i++) begin
      drive(1'b1, XW'($urandom), 1'b0, 1'b1);
      @(negedge clk);
      if (!in_ready) check($sformatf("t2_in_ready[%0d]", i), int'(in_ready), 1);
    end
    repeat (6) drive(1'b0, '0, 1'b0, 1'b1);
    check("t2_result_count", pop_cnt - p0, 300);

    // Randomized traffic with occasional frame restarts
    last_fs = 0;
    for (int i = 0; i < 3000; i++) begin
      fs = ((i - last_fs) > 30) && ($urandom_range(0, 99) < 2);
      if (fs) last_fs = i;
      drive($urandom_range(0, 9) < 7, XW'($urandom), fs, $urandom_range(0, 9) < 6);
    end
    repeat (20) drive(1'b0, '0, 1'b0, 1'b1);
    check("rand_model_empty", exp_q.size(), 0);
    @(negedge clk);
    check("rand_out_idle", int'(out_valid), 0);

    // Idle after a restart with nothing queued
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (6) drive(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    check("final_busy", int'(busy), 0);
    check("final_in_ready", int'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
